// File: rtl/ex_div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider sequencer.
// Holds the controller state encodings, word/double-word widths and flag constants.
// Imported by ex_div_ctrl and ex_div_ctrl_counter.
package ex_div_ctrl_pkg;

  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 64;

  typedef logic [WORD_W-1:0]  word_t;
  // Double-word bus: {HI = remainder, LO = quotient}.
  typedef logic [DWORD_W-1:0] dword_t;

  typedef enum logic [1:0] {
    DIVC_IDLE    = 2'd0,
    DIVC_RUN     = 2'd1,
    DIVC_DONE    = 2'd2,
    DIVC_RELEASE = 2'd3
  } divc_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ex_div_ctrl_counter.sv
// Loadable down-counter shared by the timeout and release intervals.
// Ports: load_i/load_val_i reload, dec_i decrements (saturates at 0), zero_o flags an expired count.
// Latency: one cycle from load/dec to the new count; no backpressure.
module ex_div_ctrl_counter
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i == TRUE) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ex_div_ctrl.sv
// Sequencer between EX and the multi-cycle divider: latches DIV/DIVU operands, drives start/annul,
// stalls EX while the divider runs and issues one HI/LO write when EX advances (hilo_we in DONE).
// Backpressure: ex_hold delays the write in DONE; flush/timeout annul; RELEASE enforces a start-low gap.
// Ports: clock/reset; ex_* from EX; stall_request/hilo_* to the pipeline; div_* to/from the divider.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_div_valid,
  input  logic               ex_is_signed,
  input  logic [WORD_W-1:0]  ex_operand1,
  input  logic [WORD_W-1:0]  ex_operand2,
  input  logic               ex_flush,
  input  logic               ex_hold,
  output logic               stall_request,
  output logic               hilo_we,
  output logic [DWORD_W-1:0] hilo_data,
  output logic               div_by_zero,
  output logic               div_timeout,
  output logic               div_is_start,
  output logic               div_is_annul,
  output logic               div_is_signed,
  output logic [WORD_W-1:0]  div_operand1,
  output logic [WORD_W-1:0]  div_operand2,
  input  logic               div_is_ended,
  input  logic [DWORD_W-1:0] div_result
);

  localparam int unsigned CNT_W = $clog2(max_u(TIMEOUT_CYCLES, RELEASE_CYCLES) + 1);
  // Both intervals count down to zero, so load one less than the cycle count.
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  divc_state_e state_q, state_d;
  logic   start_q,   start_d;
  logic   annul_q,   annul_d;
  logic   timeout_q, timeout_d;
  logic   signed_q,  signed_d;
  word_t  op1_q,     op1_d;
  word_t  op2_q,     op2_d;
  logic   dbz_q,     dbz_d;
  dword_t hilo_q,    hilo_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  ex_div_ctrl_counter #(.W(CNT_W)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    annul_d       = FALSE;
    timeout_d     = FALSE;
    signed_d      = signed_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    dbz_d         = dbz_q;
    hilo_d        = hilo_q;
    cnt_load      = FALSE;
    cnt_load_val  = TO_LOAD;
    cnt_dec       = FALSE;
    hilo_we       = FALSE;
    stall_request = FALSE;

    unique case (state_q)
      DIVC_IDLE: begin
        stall_request = ex_div_valid && !ex_flush;
        if (ex_div_valid && !ex_flush) begin
          signed_d     = ex_is_signed;
          op1_d        = ex_operand1;
          op2_d        = ex_operand2;
          dbz_d        = (ex_operand2 == '0);
          start_d      = ENABLE;
          cnt_load     = TRUE;
          cnt_load_val = TO_LOAD;
          state_d      = DIVC_RUN;
        end
      end

      DIVC_RUN: begin
        stall_request = TRUE;
        // Flush outranks timeout, which outranks a finished divider.
        if (ex_flush || cnt_zero) begin
          annul_d      = ENABLE;
          timeout_d    = !ex_flush;
          start_d      = DISABLE;
          cnt_load     = TRUE;
          cnt_load_val = REL_LOAD;
          state_d      = DIVC_RELEASE;
        end else if (div_is_ended) begin
          hilo_d  = div_result;
          state_d = DIVC_DONE;
        end else begin
          cnt_dec = TRUE;
        end
      end

      DIVC_DONE: begin
        // start stays high here so the divider parks in its END state.
        if (ex_flush || !ex_hold) begin
          hilo_we      = !ex_flush;
          start_d      = DISABLE;
          cnt_load     = TRUE;
          cnt_load_val = REL_LOAD;
          state_d      = DIVC_RELEASE;
        end
      end

      DIVC_RELEASE: begin
        stall_request = ex_div_valid;
        // A divider stuck in zero-divide/END ignores annul; wait for it to drop ended.
        if (cnt_zero) begin
          if (!div_is_ended) begin
            state_d = DIVC_IDLE;
          end
        end else begin
          cnt_dec = TRUE;
        end
      end

      default: begin
        state_d = DIVC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= DIVC_IDLE;
      start_q   <= FALSE;
      annul_q   <= FALSE;
      timeout_q <= FALSE;
      signed_q  <= FALSE;
      op1_q     <= '0;
      op2_q     <= '0;
      dbz_q     <= FALSE;
      hilo_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      annul_q   <= annul_d;
      timeout_q <= timeout_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      dbz_q     <= dbz_d;
      hilo_q    <= hilo_d;
    end
  end

  assign hilo_data     = hilo_q;
  assign div_by_zero   = dbz_q;
  assign div_timeout   = timeout_q;
  assign div_is_start  = start_q;
  assign div_is_annul  = annul_q;
  assign div_is_signed = signed_q;
  assign div_operand1  = op1_q;
  assign div_operand2  = op2_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl with a behavioural divider (35-cycle latency, 3 for divide-by-zero,
// optional stub mode that never finishes).
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_ex_div_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_div_valid, ex_is_signed, ex_flush, ex_hold;
    logic [31:0] ex_operand1, ex_operand2;
    logic        stall_request, hilo_we, div_by_zero, div_timeout;
    logic [63:0] hilo_data;
    logic        div_is_start, div_is_annul, div_is_signed;
    logic [31:0] div_operand1, div_operand2;
    logic        div_is_ended = 1'b0;
    logic [63:0] div_result = 64'd0;

    logic stub_mode = 1'b0;
    int   dv_cnt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   we_cnt = 0;
    int   annul_cnt = 0;

    always #5 clock = ~clock;

    ex_div_ctrl #(.TIMEOUT_CYCLES(48), .RELEASE_CYCLES(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_div_valid  (ex_div_valid),
        .ex_is_signed  (ex_is_signed),
        .ex_operand1   (ex_operand1),
        .ex_operand2   (ex_operand2),
        .ex_flush      (ex_flush),
        .ex_hold       (ex_hold),
        .stall_request (stall_request),
        .hilo_we       (hilo_we),
        .hilo_data     (hilo_data),
        .div_by_zero   (div_by_zero),
        .div_timeout   (div_timeout),
        .div_is_start  (div_is_start),
        .div_is_annul  (div_is_annul),
        .div_is_signed (div_is_signed),
        .div_operand1  (div_operand1),
        .div_operand2  (div_operand2),
        .div_is_ended  (div_is_ended),
        .div_result    (div_result)
    );

    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clock) begin
        if (!div_is_start || div_is_annul) begin
            dv_cnt       <= 0;
            div_is_ended <= 1'b0;
        end else if (!div_is_ended && !stub_mode) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt + 1 == ((div_operand2 == 32'd0) ? 3 : 35)) begin
                div_is_ended <= 1'b1;
                div_result   <= div_model(div_is_signed, div_operand1, div_operand2);
            end
        end
    end

    always @(negedge clock) begin
        if (hilo_we === 1'b1) we_cnt++;
        if (div_is_annul === 1'b1) annul_cnt++;
        if (reset === 1'b1) begin
            n_cmp++;
            if (hilo_we === 1'b1 && div_timeout === 1'b1) begin
                n_fail++;
                $error("FAIL mon_we_timeout: hilo_we together with div_timeout");
            end
            n_cmp++;
            if (hilo_we === 1'b1 && div_is_annul === 1'b1) begin
                n_fail++;
                $error("FAIL mon_we_annul: hilo_we together with div_is_annul");
            end
            n_cmp++;
            if (hilo_we === 1'b1 && stall_request !== 1'b0) begin
                n_fail++;
                $error("FAIL mon_we_stall: stall_request high during hilo_we");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_we(input int max, output int n);
        n = 0;
        while (hilo_we !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a0, w0;
        logic ok;
        ex_div_valid = 0; ex_is_signed = 0; ex_flush = 0; ex_hold = 0;
        ex_operand1 = 0; ex_operand2 = 0;
        #1 reset = 1'b0;
        tick(); tick();
        `CHK("rst_start", div_is_start, 0);
        `CHK("rst_annul", div_is_annul, 0);
        `CHK("rst_timeout", div_timeout, 0);
        `CHK("rst_dbz", div_by_zero, 0);
        `CHK("rst_hilo", hilo_data, 0);
        `CHK("rst_we", hilo_we, 0);
        `CHK("rst_stall", stall_request, 0);
        reset = 1'b1;
        tick();

        ex_div_valid = 1; ex_is_signed = 1; ex_operand1 = 32'd100; ex_operand2 = 32'hFFFF_FFF9;
        #1 `CHK("t1_stall_idle", stall_request, 1);
        w0 = we_cnt;
        tick();
        `CHK("t1_start", div_is_start, 1);
        `CHK("t1_signed", div_is_signed, 1);
        `CHK("t1_op2", div_operand2, 32'hFFFF_FFF9);
        `CHK("t1_dbz", div_by_zero, 0);
        n = 0; ok = 1'b1;
        while (hilo_we !== 1'b1 && n < 60) begin
            if (stall_request !== 1'b1) ok = 1'b0;
            tick();
            n++;
        end
        `CHK("t1_latency", n, 36);
        `CHK("t1_stall_run", ok, 1);
        `CHK("t1_stall_done", stall_request, 0);
        `CHK("t1_hilo", hilo_data, 64'h0000_0002_FFFF_FFF2);
        ex_div_valid = 0;
        tick();
        `CHK("t1_we_drop", hilo_we, 0);
        repeat (4) tick();
        `CHK("t1_we_once", we_cnt - w0, 1);

        ex_div_valid = 1; ex_is_signed = 0; ex_operand1 = 32'hFFFF_FFFF; ex_operand2 = 32'd0;
        tick();
        `CHK("t2_dbz", div_by_zero, 1);
        wait_we(10, n);
        `CHK("t2_latency", n, 4);
        `CHK("t2_hilo", hilo_data, 0);
        ex_div_valid = 0;
        repeat (5) tick();
        `CHK("t2_dbz_sticky", div_by_zero, 1);

        ex_div_valid = 1; ex_is_signed = 1; ex_operand1 = 32'd1000; ex_operand2 = 32'd3;
        tick();
        `CHK("t3_dbz_clear", div_by_zero, 0);
        a0 = annul_cnt; w0 = we_cnt;
        repeat (10) tick();
        ex_flush = 1;
        tick();
        ex_flush = 0;
        ex_operand1 = 32'd84; ex_operand2 = 32'hFFFF_FFFC;
        #1;
        `CHK("t3_annul", div_is_annul, 1);
        `CHK("t3_start_off", div_is_start, 0);
        `CHK("t3_stall_rel", stall_request, 1);
        tick();
        `CHK("t3_annul_pulse", div_is_annul, 0);
        `CHK("t3_start_rel1", div_is_start, 0);
        tick();
        `CHK("t3_start_rel2", div_is_start, 0);
        tick();
        `CHK("t3_start_acc", div_is_start, 1);
        `CHK("t3_op1", div_operand1, 32'd84);
        wait_we(60, n);
        `CHK("t3_latency", n, 36);
        `CHK("t3_hilo", hilo_data, 64'h0000_0000_FFFF_FFEB);
        ex_div_valid = 0;
        repeat (4) tick();
        `CHK("t3_annul_cnt", annul_cnt - a0, 1);
        `CHK("t3_we_cnt", we_cnt - w0, 1);

        ex_div_valid = 1; ex_is_signed = 0; ex_operand1 = 32'd7; ex_operand2 = 32'd2; ex_hold = 1;
        tick();
        n = 0;
        while (stall_request === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        `CHK("t4_done_at", n, 36);
        ok = (hilo_we === 1'b0);
        repeat (4) begin
            tick();
            if (hilo_we !== 1'b0) ok = 1'b0;
        end
        `CHK("t4_held", ok, 1);
        w0 = we_cnt;
        ex_hold = 0;
        #1 `CHK("t4_we", hilo_we, 1);
        `CHK("t4_hilo", hilo_data, 64'h0000_0001_0000_0003);
        ex_div_valid = 0;
        tick();
        `CHK("t4_we_drop", hilo_we, 0);
        repeat (3) tick();
        `CHK("t4_we_once", we_cnt - w0, 1);

        ex_div_valid = 1; ex_is_signed = 0; ex_operand1 = 32'd50; ex_operand2 = 32'd5;
        tick();
        wait_we(60, n);
        `CHK("t5a_hilo", hilo_data, 64'h0000_0000_0000_000A);
        ex_operand1 = 32'd9; ex_operand2 = 32'd2;
        tick();
        `CHK("t5_stall_r1", stall_request, 1);
        `CHK("t5_start_r1", div_is_start, 0);
        tick();
        `CHK("t5_stall_r2", stall_request, 1);
        `CHK("t5_start_r2", div_is_start, 0);
        tick();
        `CHK("t5_start_r3", div_is_start, 0);
        tick();
        `CHK("t5_start_acc", div_is_start, 1);
        `CHK("t5_op1", div_operand1, 32'd9);
        wait_we(60, n);
        `CHK("t5b_latency", n, 36);
        `CHK("t5b_hilo", hilo_data, 64'h0000_0001_0000_0004);
        ex_div_valid = 0;
        repeat (4) tick();

        ex_div_valid = 1; ex_flush = 1; ex_operand1 = 32'd5; ex_operand2 = 32'd1;
        #1 `CHK("t6_flush_stall", stall_request, 0);
        tick();
        `CHK("t6_flush_noacc", div_is_start, 0);
        ex_div_valid = 0; ex_flush = 0;
        tick();

        stub_mode = 1;
        ex_div_valid = 1; ex_is_signed = 0; ex_operand1 = 32'd10; ex_operand2 = 32'd3;
        tick();
        a0 = annul_cnt; w0 = we_cnt;
        n = 0;
        while (div_timeout !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        `CHK("t7_timeout_at", n, 48);
        `CHK("t7_annul", div_is_annul, 1);
        `CHK("t7_start_off", div_is_start, 0);
        ex_div_valid = 0;
        tick();
        `CHK("t7_timeout_pulse", div_timeout, 0);
        repeat (3) tick();
        `CHK("t7_no_we", we_cnt - w0, 0);
        `CHK("t7_annul_cnt", annul_cnt - a0, 1);
        ex_div_valid = 1;
        tick();
        `CHK("t7_reaccept", div_is_start, 1);
        repeat (5) tick();
        ex_div_valid = 0;
        #2 reset = 1'b0;
        #1;
        `CHK("t8_rst_start", div_is_start, 0);
        `CHK("t8_rst_hilo", hilo_data, 0);
        `CHK("t8_rst_op1", div_operand1, 0);
        `CHK("t8_rst_stall", stall_request, 0);
        `CHK("t8_rst_annul", div_is_annul, 0);
        `CHK("t8_rst_timeout", div_timeout, 0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Sequencer between the EX stage and the multi-cycle `ex_div` divider.
- Accepts a DIV/DIVU from EX, latches its operands, and drives the divider's start/annul handshake.
- Stalls the pipeline while the division runs, then issues one HI/LO write when EX advances.
- Handles flush mid-division, a hung divider (timeout), and a guaranteed divider release period before the next division.

## Interface
Parameters:
- TIMEOUT_CYCLES, 48: maximum RUN cycles without `div_is_ended` before abort.
- RELEASE_CYCLES, 2: minimum cycles `div_is_start` is held low between divisions (≥2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- ex_div_valid  in  1  EX holds a DIV/DIVU.
- ex_is_signed  in  1  1 = DIV, 0 = DIVU.
- ex_operand1  in  32  dividend.
- ex_operand2  in  32  divisor.
- ex_flush  in  1  EX instruction annulled (exception/branch flush).
- ex_hold  in  1  downstream stall; EX cannot advance this cycle.
- stall_request  out  1  combinational; holds EX.
- hilo_we  out  1  HI/LO write strobe.
- hilo_data  out  64  {HI = remainder, LO = quotient}.
- div_by_zero  out  1  sticky per division; divisor was 0.
- div_timeout  out  1  one-cycle pulse on abort.
- div_is_start  out  1  to divider.
- div_is_annul  out  1  to divider.
- div_is_signed  out  1  to divider.
- div_operand1  out  32  to divider.
- div_operand2  out  32  to divider.
- div_is_ended  in  1  from divider.
- div_result  in  64  from divider.

## Operation
- State machine: IDLE, RUN, DONE, RELEASE. Reset enters IDLE; every registered output resets to 0.
- IDLE:
  - Condition: `ex_div_valid` and not `ex_flush`.
  - Action: latch `ex_is_signed` and both operands into the `div_*` registers, set `div_by_zero` = (operand2 == 0), set `div_is_start` = 1, clear the timeout counter, go to RUN.
- Operand stability: `div_*` operands and sign stay constant from acceptance until RELEASE exits. The divider re-reads them during its final correction step.
- RUN, checks in priority order:
  - `ex_flush`: `div_is_annul` = 1 for one cycle, `div_is_start` = 0, go to RELEASE. No write.
  - Counter reaches TIMEOUT_CYCLES: same as flush, plus a `div_timeout` pulse. No write.
  - `div_is_ended`: latch `div_result` into `hilo_data`, go to DONE.
  - Otherwise: increment the counter.
- DONE:
  - `div_is_start` stays 1, so the divider holds its END state.
  - If `ex_flush`: no write, go to RELEASE.
  - Else if not `ex_hold`: `hilo_we` = 1 for exactly this cycle, go to RELEASE.
  - Else: wait.
- RELEASE:
  - `div_is_start` = 0 and `div_is_annul` = 0; load the release counter.
  - Exit to IDLE only when the counter has expired AND `div_is_ended` = 0.
  - This covers a divider caught in its zero-divide/end states, where annul is ignored.
- `stall_request`:
  - IDLE: `ex_div_valid` and not `ex_flush`.
  - RUN: 1.
  - DONE: 0.
  - RELEASE: `ex_div_valid` (a back-to-back division waits).
- `hilo_data` holds its value after the write; it is only qualified by `hilo_we`.
- `div_by_zero` clears on the next acceptance.
- Simultaneous events:
  - Flush beats timeout, which beats ended.
  - `ex_flush` together with an ended divider discards the result.
- Reset mid-operation: immediate IDLE with outputs 0. The divider's own reset is separate.

## Timing
- Acceptance at edge E0 (`div_is_start` high after E0).
- With the current divider, `div_is_ended` rises after E35 (E3 for divide-by-zero).
- The controller must work for any latency below TIMEOUT_CYCLES.
- `div_is_ended` seen high → DONE at the next edge. `hilo_we` in the first DONE cycle with `ex_hold` = 0.
- Result-to-next-accept: ≥ RELEASE_CYCLES + 1 cycles.
- `hilo_we` is never asserted twice per accepted division.
- Timeout/flush never produce `hilo_we`.

## Structure
- Shared defines header holds:
  - the state encodings (DIVC_IDLE, DIVC_RUN, DIVC_DONE, DIVC_RELEASE);
  - the existing `TRUE`/`FALSE`/`ENABLE` and bus-width macros;
  - the 64-bit double-word bus macro.
- One sub-module is natural: `ex_div_ctrl_counter`, a loadable down-counter shared by the timeout and release counts.
- The bench instantiates `ex_div_ctrl` together with the real `ex_div` divider.

## Test plan
- DIV 100 / −7, `ex_hold` = 0:
  - `stall_request` high from acceptance until DONE;
  - one `hilo_we` with `hilo_data` = {0x00000002, 0xFFFFFFF2};
  - ~37 cycles total.
- DIVU 0xFFFFFFFF / 0: `div_by_zero` = 1, `hilo_data` = 0, write within 5 cycles.
- `ex_flush` at RUN cycle 10:
  - `div_is_annul` pulses once;
  - no `hilo_we`;
  - next DIV accepted only after RELEASE, with a correct result.
- `ex_hold` high for 5 cycles in DONE: `hilo_we` asserts only on the cycle `ex_hold` falls, exactly once.
- Back-to-back DIVU 50/5 then 9/2:
  - second division stalls through RELEASE;
  - writes {0, 10} then {1, 4}.
- Stubbed divider that never asserts `div_is_ended`:
  - `div_timeout` pulses after 48 RUN cycles;
  - `div_is_annul` pulses;
  - return to IDLE;
  - asynchronous reset asserted mid-RUN clears all outputs immediately.
